// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed driver for an N_DIG-digit 7-segment display.
//
// One digit is enabled at a time. Each digit stays enabled for a slot of
// SCAN_DIV clocks. The first GAP clocks of every slot have all digits off, to
// avoid ghosting. Digit codes, decimal points, blanks and the leading-zero
// enable are captured into shadow registers when scanning starts and again at
// every frame wrap, so a number never tears mid-frame.
//
// Ports
//   clk    in   1        system clock
//   rst    in   1        synchronous reset, active-high
//   st     in   1        scan enable; 0 = display dark, scanner parked
//   num    in   4*N_DIG  digit codes, num[4i+3:4i] = digit i (digit 0 = LSD)
//   dp     in   N_DIG    decimal point per digit
//   blank  in   N_DIG    force digit dark (segments and dp)
//   lz_en  in   1        leading-zero suppression enable
//   seg    out  8        {a,b,c,d,e,f,g,dp}, active-high
//   dig    out  N_DIG    one-hot digit enable, polarity set by DIG_ACT_LOW
//   frame  out  1        1-cycle pulse when the digit index wraps to 0
module disp_scan #(
  parameter int unsigned N_DIG       = 8,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned GAP         = 16,
  parameter bit          HEX_EN      = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [4*N_DIG-1:0] num,
  input  logic [N_DIG-1:0]   dp,
  input  logic [N_DIG-1:0]   blank,
  input  logic               lz_en,
  output logic [7:0]         seg,
  output logic [N_DIG-1:0]   dig,
  output logic               frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CW-1:0]    CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]    CNT_GAP  = CW'(GAP);
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] DIG_OFF  = {N_DIG{DIG_ACT_LOW}};

  typedef enum logic {
    S_PARK,
    S_SCAN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic [4*N_DIG-1:0] num_q, num_d;
  logic [N_DIG-1:0]   dp_q, dp_d;
  logic [N_DIG-1:0]   blank_q, blank_d;
  logic               lz_q, lz_d;

  logic [7:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   dig_q, dig_d;
  logic               frame_q, frame_d;

  logic               start;
  logic               slot_end;
  logic               wrap;
  logic               load;

  // Display source: on the start cycle the shadows are not loaded yet, so
  // the live inputs are shown directly to keep the first slot consistent.
  logic [4*N_DIG-1:0] src_num;
  logic [N_DIG-1:0]   src_dp;
  logic [N_DIG-1:0]   src_blank;
  logic               src_lz;

  logic [3:0]         cur_code;
  logic [IW-1:0]      hi_nz;
  logic [N_DIG-1:0]   dig_on;
  logic               lz_sup;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'h0:    s = 8'hFC;
      4'h1:    s = 8'h60;
      4'h2:    s = 8'hDA;
      4'h3:    s = 8'hF2;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'hB6;
      4'h6:    s = 8'hBE;
      4'h7:    s = 8'hE0;
      4'h8:    s = 8'hFE;
      4'h9:    s = 8'hF6;
      4'hA:    s = 8'hEE;
      4'hB:    s = 8'h3E;
      4'hC:    s = 8'h9C;
      4'hD:    s = 8'h7A;
      4'hE:    s = 8'h9E;
      default: s = 8'h8E;
    endcase
    if (!HEX_EN && (code > 4'd9)) begin
      s = '0;
    end
    return s;
  endfunction

  // Scan control: parked while st is low, scanning otherwise.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    if (!st) begin
      state_d = S_PARK;
    end else begin
      state_d = S_SCAN;
      start   = (state_q == S_PARK);
    end
  end

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = st && slot_end && (idx_q == IDX_LAST);
    load     = start || wrap;

    cnt_d = '0;
    idx_d = '0;
    if (st) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
    end
  end

  always_comb begin
    num_d   = num_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    lz_d    = lz_q;
    if (load) begin
      num_d   = num;
      dp_d    = dp;
      blank_d = blank;
      lz_d    = lz_en;
    end

    src_num   = start ? num   : num_q;
    src_dp    = start ? dp    : dp_q;
    src_blank = start ? blank : blank_q;
    src_lz    = start ? lz_en : lz_q;
  end

  // Current code, highest nonzero digit and one-hot position of idx.
  always_comb begin
    cur_code = '0;
    hi_nz    = '0;
    dig_on   = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (IW'(i) == idx_q) begin
        cur_code  = src_num[4*i +: 4];
        dig_on[i] = 1'b1;
      end
      if (src_num[4*i +: 4] != 4'd0) begin
        hi_nz = IW'(i);
      end
    end
    // hi_nz is at least 0, so digit 0 can never be suppressed.
    lz_sup = src_lz && (idx_q > hi_nz);
  end

  always_comb begin
    seg_d   = '0;
    dig_d   = DIG_OFF;
    frame_d = 1'b0;
    if (st) begin
      frame_d = wrap;
      if (cnt_q >= CNT_GAP) begin
        dig_d = dig_on ^ DIG_OFF;
      end
      if ((src_blank & dig_on) == '0) begin
        seg_d    = lz_sup ? 8'h00 : seg_decode(cur_code);
        seg_d[0] = |(src_dp & dig_on);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PARK;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      seg_q   <= '0;
      dig_q   <= DIG_OFF;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      lz_q    <= lz_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

  localparam int ND   = 4;
  localparam int SD   = 8;
  localparam int GAP0 = 2;
  localparam int GAP1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [15:0] num;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;

  logic [7:0]  seg0, seg1;
  logic [3:0]  dig0, dig1;
  logic        frame0, frame1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scan #(
    .N_DIG(ND), .SCAN_DIV(SD), .GAP(GAP0), .HEX_EN(1'b1), .DIG_ACT_LOW(1'b1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .st(st), .num(num), .dp(dp), .blank(blank),
    .lz_en(lz_en), .seg(seg0), .dig(dig0), .frame(frame0)
  );

  disp_scan #(
    .N_DIG(ND), .SCAN_DIV(SD), .GAP(GAP1), .HEX_EN(1'b0), .DIG_ACT_LOW(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .st(st), .num(num), .dp(dp), .blank(blank),
    .lz_en(lz_en), .seg(seg1), .dig(dig1), .frame(frame1)
  );

  typedef struct {
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: elapsed scan time t gives slot and phase directly.
  logic [7:0] DEC [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int         t = 0;
  bit         running = 0;
  int         sh_num [ND];
  bit         sh_dp  [ND];
  bit         sh_bl  [ND];
  bit         sh_lz;

  function automatic logic [7:0] model_seg(int d, bit hex, int hi);
    logic [7:0] s;
    if (sh_bl[d]) return 8'h00;
    if (sh_lz && d > hi)           s = 8'h00;
    else if (sh_num[d] > 9 && !hex) s = 8'h00;
    else                            s = DEC[sh_num[d]];
    if (sh_dp[d]) s = s + 8'h01;
    return s;
  endfunction

  task automatic load_shadow();
    for (int i = 0; i < ND; i++) begin
      sh_num[i] = int'(num[4*i +: 4]);
      sh_dp[i]  = dp[i];
      sh_bl[i]  = blank[i];
    end
    sh_lz = lz_en;
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   phase, d, hi;
    e.seg0 = 8'h00; e.seg1 = 8'h00;
    e.dig0 = 4'hF;  e.dig1 = 4'h0;
    e.fr   = 1'b0;
    if (rst) begin
      for (int i = 0; i < ND; i++) begin
        sh_num[i] = 0; sh_dp[i] = 0; sh_bl[i] = 0;
      end
      sh_lz = 0; running = 0; t = 0;
    end else if (!st) begin
      running = 0; t = 0;
    end else begin
      if (!running) begin
        load_shadow();
        running = 1;
      end
      phase = t % SD;
      d     = (t / SD) % ND;
      hi    = 0;
      for (int i = 0; i < ND; i++) if (sh_num[i] != 0) hi = i;
      e.fr   = (phase == SD - 1) && (d == ND - 1);
      e.seg0 = model_seg(d, 1'b1, hi);
      e.seg1 = model_seg(d, 1'b0, hi);
      if (phase >= GAP0) e.dig0 = ~(4'b0001 << d);
      if (phase >= GAP1) e.dig1 = 4'b0001 << d;
      if (e.fr) load_shadow();
      t++;
    end
    exp_q.push_back(e);
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are registered, so each cycle presents one response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg0",   seg0,            e.seg0);
      check("dig0",   {4'h0, dig0},    {4'h0, e.dig0});
      check("frame0", {7'h0, frame0},  {7'h0, e.fr});
      check("seg1",   seg1,            e.seg1);
      check("dig1",   {4'h0, dig1},    {4'h0, e.dig1});
      check("frame1", {7'h0, frame1},  {7'h0, e.fr});
    end
  end

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; st = 1'b1; num = 16'h9876; dp = 4'hF; blank = 4'h0; lz_en = 1'b0;
    run(2);
    rst = 1'b0;

    // Basic scan of 4321
    num = 16'h4321; dp = 4'h0;
    run(70);

    // Tear-free update mid-frame
    num = 16'h1111;
    run(40);
    run(11);
    num = 16'h2222;
    run(50);

    // Hex code with dp on digit 0
    num = 16'h000A; dp = 4'h0;
    run(40);
    num = 16'h0000; dp = 4'h1;
    run(40);
    num = 16'hFCBA; dp = 4'h0;
    run(40);

    // Leading-zero suppression
    num = 16'h0050; lz_en = 1'b1;
    run(70);
    num = 16'h0000; dp = 4'b1000;
    run(70);
    dp = 4'h0; blank = 4'b0101; num = 16'h0306;
    run(70);
    blank = 4'h0; lz_en = 1'b0;

    // Abort mid-slot, then restart
    num = 16'h8765;
    run(13);
    st = 1'b0;
    run(5);
    num = 16'h1234;
    st = 1'b1;
    run(45);

    // Reset mid-frame clears shadows
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(40);

    // Randomized segments
    for (int k = 0; k < 60; k++) begin
      num   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_en = 1'($urandom);
      st    = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 24) == 0);
      run($urandom_range(1, 45));
      rst   = 1'b0;
    end
    st = 1'b1;
    run(40);

    @(negedge clk);
    #1;
    check("drain", 8'(exp_q.size() > 1), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
